systolic_sequencer: RTL and testbench

Sequences one 2xK by Kx2 signed matrix multiply through the 2x2 systolic matrix. Accepts column-of-A / row-of-B beats over a valid/ready stream and clears the array accumulators before each job. Applies the diagonal input skew, drains the pipeline, and captures c11..c22 into a held result with a valid/ready handshake. Sits between the host-side operand buffer and the systolic matrix instance.

---
 rtl/systolic_sequencer.sv | 159 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Sequences one 2xK by Kx2 signed multiply through a 2x2 systolic array:
// clears the accumulators, streams diagonally skewed beats, drains, then holds the result.
module systolic_sequencer #(
   parameter int unsigned indata_size  = 8,
   parameter int unsigned K            = 2,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [indata_size-1:0]   in_a0,
   input  logic [indata_size-1:0]   in_a1,
   input  logic [indata_size-1:0]   in_b0,
   input  logic [indata_size-1:0]   in_b1,
   output logic                     array_clear,
   output logic [indata_size-1:0]   arr_a1X,
   output logic [indata_size-1:0]   arr_a2X,
   output logic [indata_size-1:0]   arr_bX1,
   output logic [indata_size-1:0]   arr_bX2,
   input  logic [4*indata_size-1:0] arr_c11,
   input  logic [4*indata_size-1:0] arr_c12,
   input  logic [4*indata_size-1:0] arr_c21,
   input  logic [4*indata_size-1:0] arr_c22,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [4*indata_size-1:0] out_c11,
   output logic [4*indata_size-1:0] out_c12,
   output logic [4*indata_size-1:0] out_c21,
   output logic [4*indata_size-1:0] out_c22
);

   localparam int unsigned BEAT_W  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]             state;
   logic [2:0]             state_nxt;
   logic [BEAT_W-1:0]      beat_cnt;
   logic [DRAIN_W-1:0]     drain_cnt;
   logic [indata_size-1:0] skew_a;
   logic [indata_size-1:0] skew_b;
   logic                   beat_hs;
   logic                   last_beat;
   logic                   drain_last;

   // in_ready is only ever high in STREAM, so it qualifies the handshake on its own
   assign beat_hs    = in_valid & in_ready;
   assign last_beat  = (beat_cnt == BEAT_W'(K - 1));
   assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_CLEAR;
         S_CLEAR:  state_nxt = S_STREAM;
         S_STREAM: if (beat_hs && last_beat) state_nxt = S_DRAIN;
         S_DRAIN:  if (drain_last) state_nxt = S_DONE;
         S_DONE:   if (out_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Control outputs registered from the next state so they line up with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy        <= 1'b0;
         in_ready    <= 1'b0;
         array_clear <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         busy        <= (state_nxt != S_IDLE);
         in_ready    <= (state_nxt == S_STREAM);
         array_clear <= (state_nxt == S_CLEAR);
         out_valid   <= (state_nxt == S_DONE);
      end
   end

   // Beat and drain counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               beat_cnt  <= '0;
               drain_cnt <= '0;
            end
            S_STREAM: if (beat_hs) beat_cnt <= beat_cnt + BEAT_W'(1);
            S_DRAIN:  drain_cnt <= drain_cnt + DRAIN_W'(1);
            default: ;
         endcase
      end
   end

   // Operand lanes: row/column 0 go straight out, row/column 1 pass through one skew stage.
   // Bubbles and drain cycles inject zeros so every product stays aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arr_a1X <= '0;
         arr_bX1 <= '0;
         arr_a2X <= '0;
         arr_bX2 <= '0;
         skew_a  <= '0;
         skew_b  <= '0;
      end else begin
         arr_a1X <= '0;
         arr_bX1 <= '0;
         arr_a2X <= '0;
         arr_bX2 <= '0;
         skew_a  <= '0;
         skew_b  <= '0;
         if (state == S_STREAM || state == S_DRAIN) begin
            arr_a2X <= skew_a;
            arr_bX2 <= skew_b;
         end
         if (state == S_STREAM && beat_hs) begin
            arr_a1X <= in_a0;
            arr_bX1 <= in_b0;
            skew_a  <= in_a1;
            skew_b  <= in_b1;
         end
      end
   end

   // Result capture on the DRAIN -> DONE edge; held until the next capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_c11 <= '0;
         out_c12 <= '0;
         out_c21 <= '0;
         out_c22 <= '0;
      end else if (state == S_DRAIN && drain_last) begin
         out_c11 <= arr_c11;
         out_c12 <= arr_c12;
         out_c21 <= arr_c21;
         out_c22 <= arr_c22;
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: K=2 and K=4 instances, each closed through a behavioural 2x2 array,
// with results compared against a plain matrix-product reference.
module tb_systolic_sequencer;

   localparam int unsigned W     = 8;
   localparam int unsigned CW    = 4 * W;
   localparam int unsigned DRAIN = 3;
   localparam int unsigned OW    = 4 + 4 * W + 4 * CW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                 start [2];
   logic                 busy [2];
   logic                 in_valid [2];
   logic                 in_ready [2];
   logic                 array_clear [2];
   logic                 out_valid [2];
   logic                 out_ready [2];
   logic signed [W-1:0]  in_a0 [2];
   logic signed [W-1:0]  in_a1 [2];
   logic signed [W-1:0]  in_b0 [2];
   logic signed [W-1:0]  in_b1 [2];
   logic signed [W-1:0]  arr_a1X [2];
   logic signed [W-1:0]  arr_a2X [2];
   logic signed [W-1:0]  arr_bX1 [2];
   logic signed [W-1:0]  arr_bX2 [2];
   logic signed [CW-1:0] arr_c11 [2];
   logic signed [CW-1:0] arr_c12 [2];
   logic signed [CW-1:0] arr_c21 [2];
   logic signed [CW-1:0] arr_c22 [2];
   logic signed [CW-1:0] out_c11 [2];
   logic signed [CW-1:0] out_c12 [2];
   logic signed [CW-1:0] out_c21 [2];
   logic signed [CW-1:0] out_c22 [2];

   int checks   = 0;
   int failures = 0;

   logic signed [W-1:0]  ja [2][4];   // A[row][k]
   logic signed [W-1:0]  jb [4][2];   // B[k][col]
   logic signed [CW-1:0] exp_c [4];   // c11, c12, c21, c22
   logic signed [W-1:0]  lag_a;
   logic signed [W-1:0]  lag_b;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      systolic_sequencer #(
         .indata_size (W),
         .K           ((g == 0) ? 2 : 4),
         .DRAIN_CYCLES(DRAIN)
      ) dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start[g]),
         .busy       (busy[g]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .in_a0      (in_a0[g]),
         .in_a1      (in_a1[g]),
         .in_b0      (in_b0[g]),
         .in_b1      (in_b1[g]),
         .array_clear(array_clear[g]),
         .arr_a1X    (arr_a1X[g]),
         .arr_a2X    (arr_a2X[g]),
         .arr_bX1    (arr_bX1[g]),
         .arr_bX2    (arr_bX2[g]),
         .arr_c11    (arr_c11[g]),
         .arr_c12    (arr_c12[g]),
         .arr_c21    (arr_c21[g]),
         .arr_c22    (arr_c22[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .out_c11    (out_c11[g]),
         .out_c12    (out_c12[g]),
         .out_c21    (out_c21[g]),
         .out_c22    (out_c22[g])
      );

      // Behavioural array: registered operand hops between PEs, accumulators cleared by array_clear,
      // and each PE's sum output already includes the product it sees this cycle.
      logic signed [W-1:0]  ha11 = '0, hb11 = '0, ha21 = '0, hb12 = '0;
      logic signed [CW-1:0] acc11 = '0, acc12 = '0, acc21 = '0, acc22 = '0;
      logic signed [CW-1:0] p11, p12, p21, p22;

      assign p11 = CW'(arr_a1X[g]) * CW'(arr_bX1[g]);
      assign p12 = CW'(ha11) * CW'(arr_bX2[g]);
      assign p21 = CW'(arr_a2X[g]) * CW'(hb11);
      assign p22 = CW'(ha21) * CW'(hb12);

      always @(posedge clk) begin
         ha11 <= arr_a1X[g];
         hb11 <= arr_bX1[g];
         ha21 <= arr_a2X[g];
         hb12 <= arr_bX2[g];
         if (array_clear[g]) begin
            acc11 <= '0;
            acc12 <= '0;
            acc21 <= '0;
            acc22 <= '0;
         end else begin
            acc11 <= acc11 + p11;
            acc12 <= acc12 + p12;
            acc21 <= acc21 + p21;
            acc22 <= acc22 + p22;
         end
      end

      assign arr_c11[g] = acc11 + p11;
      assign arr_c12[g] = acc12 + p12;
      assign arr_c21[g] = acc21 + p21;
      assign arr_c22[g] = acc22 + p22;
   end

   function automatic logic [OW-1:0] all_outs(input int g);
      return {busy[g], in_ready[g], array_clear[g], out_valid[g],
              arr_a1X[g], arr_a2X[g], arr_bX1[g], arr_bX2[g],
              out_c11[g], out_c12[g], out_c21[g], out_c22[g]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_job_2(input int a00, input int a01, input int a10, input int a11,
                            input int b00, input int b01, input int b10, input int b11);
      ja[0][0] = W'(a00); ja[0][1] = W'(a01);
      ja[1][0] = W'(a10); ja[1][1] = W'(a11);
      jb[0][0] = W'(b00); jb[0][1] = W'(b01);
      jb[1][0] = W'(b10); jb[1][1] = W'(b11);
   endtask

   task automatic compute_ref(input int kk);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            exp_c[2*i+j] = '0;
            for (int k = 0; k < kk; k++) exp_c[2*i+j] += CW'(ja[i][k]) * CW'(jb[k][j]);
         end
      end
   endtask

   // One clock; hs says whether the bench is presenting an accepted beat this cycle.
   // Afterwards the straight lanes must show this beat and the skewed lanes the previous one.
   task automatic step(input int g, input bit hs, input bit chk);
      logic signed [W-1:0] a0, a1, b0, b1;
      a0 = hs ? in_a0[g] : '0;
      a1 = hs ? in_a1[g] : '0;
      b0 = hs ? in_b0[g] : '0;
      b1 = hs ? in_b1[g] : '0;
      tick();
      if (chk) begin
         checks++;
         if ({arr_a1X[g], arr_bX1[g], arr_a2X[g], arr_bX2[g]} !== {a0, b0, lag_a, lag_b}) begin
            failures++;
            $display("FAIL lane_skew g=%0d got=%h exp=%h", g,
                     {arr_a1X[g], arr_bX1[g], arr_a2X[g], arr_bX2[g]}, {a0, b0, lag_a, lag_b});
         end
      end
      lag_a = a1;
      lag_b = b1;
   endtask

   task automatic run_job(input int g, input int kk, input int gap, input bit rnd_gap, input bit chk);
      int t, bubbles, ng;
      out_ready[g] = 1'b0;
      compute_ref(kk);
      checks++;
      if (busy[g] !== 1'b0) begin
         failures++;
         $display("FAIL idle_before_start g=%0d got=%b exp=0", g, busy[g]);
      end
      start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
      t = 1;
      checks++;
      if ({array_clear[g], busy[g], in_ready[g]} !== 3'b110) begin
         failures++;
         $display("FAIL clear_pulse g=%0d got=%b exp=110", g, {array_clear[g], busy[g], in_ready[g]});
      end
      lag_a = '0;
      lag_b = '0;
      tick();
      t = 2;
      checks++;
      if ({array_clear[g], in_ready[g]} !== 2'b01) begin
         failures++;
         $display("FAIL stream_entry g=%0d got=%b exp=01", g, {array_clear[g], in_ready[g]});
      end
      bubbles = 0;
      for (int k = 0; k < kk; k++) begin
         ng = (k == 0) ? 0 : (rnd_gap ? int'($urandom_range(0, gap)) : gap);
         for (int b = 0; b < ng; b++) begin
            in_valid[g] = 1'b0;
            in_a0[g] = W'($urandom); in_a1[g] = W'($urandom);
            in_b0[g] = W'($urandom); in_b1[g] = W'($urandom);
            step(g, 1'b0, chk);
            t++;
            bubbles++;
         end
         checks++;
         if (in_ready[g] !== 1'b1) begin
            failures++;
            $display("FAIL ready_in_stream g=%0d beat=%0d got=%b exp=1", g, k, in_ready[g]);
         end
         in_valid[g] = 1'b1;
         in_a0[g] = ja[0][k]; in_a1[g] = ja[1][k];
         in_b0[g] = jb[k][0]; in_b1[g] = jb[k][1];
         step(g, 1'b1, chk);
         t++;
      end
      in_valid[g] = 1'b0;
      in_a0[g] = W'($urandom); in_b0[g] = W'($urandom);
      checks++;
      if (in_ready[g] !== 1'b0) begin
         failures++;
         $display("FAIL ready_drop g=%0d got=%b exp=0", g, in_ready[g]);
      end
      while (out_valid[g] !== 1'b1 && t < 200) begin
         step(g, 1'b0, chk);
         t++;
      end
      checks++;
      if (t != kk + int'(DRAIN) + 2 + bubbles) begin
         failures++;
         $display("FAIL latency g=%0d got=%0d exp=%0d", g, t, kk + int'(DRAIN) + 2 + bubbles);
      end
      checks++;
      if ({out_c11[g], out_c12[g], out_c21[g], out_c22[g]} !== {exp_c[0], exp_c[1], exp_c[2], exp_c[3]}) begin
         failures++;
         $display("FAIL result g=%0d got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", g,
                  out_c11[g], out_c12[g], out_c21[g], out_c22[g], exp_c[0], exp_c[1], exp_c[2], exp_c[3]);
      end
   endtask

   // Hold the result for `hold` cycles with start pulsing (must be ignored), then consume it.
   task automatic finish_job(input int g, input int hold);
      for (int i = 0; i < hold; i++) begin
         out_ready[g] = 1'b0;
         start[g] = 1'b1;
         tick();
         checks++;
         if ({out_valid[g], busy[g], out_c11[g], out_c12[g], out_c21[g], out_c22[g]} !==
             {2'b11, exp_c[0], exp_c[1], exp_c[2], exp_c[3]}) begin
            failures++;
            $display("FAIL hold_stable g=%0d cyc=%0d got v=%b b=%b c=%0d,%0d,%0d,%0d", g, i,
                     out_valid[g], busy[g], out_c11[g], out_c12[g], out_c21[g], out_c22[g]);
         end
      end
      start[g] = 1'b0;
      out_ready[g] = 1'b1;
      tick();
      out_ready[g] = 1'b0;
      checks++;
      if ({out_valid[g], busy[g]} !== 2'b00) begin
         failures++;
         $display("FAIL release g=%0d got=%b exp=00", g, {out_valid[g], busy[g]});
      end
      tick();
      checks++;
      if (busy[g] !== 1'b0) begin
         failures++;
         $display("FAIL start_not_queued g=%0d got=%b exp=0", g, busy[g]);
      end
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #4;
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (all_outs(g) !== '0) begin
            failures++;
            $display("FAIL reset_state g=%0d got=%h exp=0", g, all_outs(g));
         end
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      set_job_2(1, 2, 3, 4, 5, 6, 7, 8);
      run_job(0, 2, 0, 1'b0, 1'b1);
      finish_job(0, 0);
   endtask

   task automatic test_signed();
      set_job_2(-1, 2, 3, -4, 5, -6, 7, 8);
      run_job(0, 2, 0, 1'b0, 1'b1);
      finish_job(0, 0);
   endtask

   task automatic test_stall();
      set_job_2(1, 2, 3, 4, 5, 6, 7, 8);
      run_job(0, 2, 3, 1'b0, 1'b1);
      finish_job(0, 0);
   endtask

   task automatic test_back_to_back();
      set_job_2(1, 2, 3, 4, 5, 6, 7, 8);
      run_job(0, 2, 0, 1'b0, 1'b0);
      finish_job(0, 5);
      set_job_2(1, 0, 0, 1, 5, 6, 7, 8);
      run_job(0, 2, 0, 1'b0, 1'b1);
      finish_job(0, 0);
   endtask

   task automatic test_reset_mid();
      set_job_2(1, 2, 3, 4, 5, 6, 7, 8);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      in_valid[0] = 1'b1;
      in_a0[0] = ja[0][0]; in_a1[0] = ja[1][0];
      in_b0[0] = jb[0][0]; in_b1[0] = jb[0][1];
      tick();
      in_valid[0] = 1'b0;
      checks++;
      if ({busy[0], arr_a1X[0]} !== {1'b1, ja[0][0]}) begin
         failures++;
         $display("FAIL mid_job_beat g=0 got=%h exp=%h", {busy[0], arr_a1X[0]}, {1'b1, ja[0][0]});
      end
      #2 reset = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (all_outs(g) !== '0) begin
            failures++;
            $display("FAIL async_reset g=%0d got=%h exp=0", g, all_outs(g));
         end
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      run_job(0, 2, 0, 1'b0, 1'b1);
      finish_job(0, 0);
   endtask

   task automatic test_k4();
      for (int k = 0; k < 4; k++) begin
         ja[0][k] = W'(1);
         ja[1][k] = W'(2);
         jb[k][0] = W'(k + 1);
         jb[k][1] = W'(1);
      end
      run_job(1, 4, 0, 1'b0, 1'b1);
      finish_job(1, 0);
   endtask

   task automatic test_random();
      int g;
      for (int n = 0; n < 12; n++) begin
         g = int'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) begin
            ja[0][k] = W'($urandom); ja[1][k] = W'($urandom);
            jb[k][0] = W'($urandom); jb[k][1] = W'($urandom);
         end
         run_job(g, (g == 0) ? 2 : 4, 2, 1'b1, 1'b1);
         finish_job(g, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0;
         in_valid[g] = 1'b0;
         out_ready[g] = 1'b0;
         in_a0[g] = '0; in_a1[g] = '0;
         in_b0[g] = '0; in_b1[g] = '0;
      end
      test_reset();
      test_basic();
      test_signed();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_k4();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
